call_stack: RTL and testbench

Parametrised return-address stack for the CPU's subroutine call/return path, sitting between the PC logic and the next-PC mux. Synchronous LIFO of `DEPTH` entries, `WIDTH` bits each, with occupancy count, full/empty flags, sticky overflow/underflow error flags, and a combinational top-of-stack output. Replaces the level-triggered stack: all state changes occur on the rising clock edge, and the flags make illegal operations visible.

---
 rtl/call_stack_pkg.sv | 15 +
 rtl/call_stack.sv | 90 +++++++++
 tb/tb_call_stack.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/call_stack_pkg.sv
// Shared CPU constants for the subroutine return path and the stack operation encoding.
package call_stack_pkg;

  localparam int PC_WIDTH  = 10;
  localparam int RAS_DEPTH = 8;

  // Encoding of {push, pop} as seen by the return-address stack.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } stack_op_e;

endpackage

// File: rtl/call_stack.sv
// Return-address stack: synchronous LIFO with occupancy, full/empty and sticky error flags.
// Top-of-stack is combinational from registered state only.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = RAS_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [CW-1:0]    sp_next;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic             ovf_set;
  logic             unf_set;
  stack_op_e        op;

  assign op      = stack_op_e'({push, pop});
  assign empty   = (sp == '0);
  assign full    = (sp == CW'(DEPTH));
  assign count   = sp;
  assign top_idx = AW'(sp - CW'(1));
  assign top     = empty ? '0 : mem[top_idx];

  always_comb begin
    sp_next = sp;
    wr_en   = 1'b0;
    wr_idx  = AW'(sp);
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          sp_next = sp + CW'(1);
        end
      end
      OP_POP: begin
        if (empty) unf_set = 1'b1;
        else       sp_next = sp - CW'(1);
      end
      OP_REPL: begin
        // Call and return together: overwrite the top; on empty it degenerates to a push.
        wr_en = 1'b1;
        if (empty) begin
          unf_set = 1'b1;
          sp_next = CW'(1);
        end else begin
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  // Storage is never cleared, but writes are blocked while reset is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_next;
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= unf_set | (underflow & ~clr_err);
      if (wr_en) mem[wr_idx] <= din;
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: vector table through a scoreboard queue, plus async-reset sequences.
module tb_call_stack;
  import call_stack_pkg::*;

  localparam int WIDTH = PC_WIDTH;
  localparam int DEPTH = RAS_DEPTH;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             push, pop, clr_err;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             empty, full, overflow, underflow;

  call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din), .clr_err(clr_err),
    .top(top), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Expectations describe outputs during the cycle the inputs are applied (before that edge).
  typedef struct {
    logic        p, q, c;
    logic [9:0]  d;
    logic [9:0]  e_top;
    int          e_cnt;
    logic        e_emp, e_full, e_ovf, e_unf;
  } vec_t;

  typedef struct {
    logic [9:0] top;
    int         cnt;
    logic       emp, full, ovf, unf;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic p, logic q, logic c, logic [9:0] d, logic [9:0] t,
                              int n, logic e, logic f, logic o, logic u);
    vec_t v;
    v.p = p; v.q = q; v.c = c; v.d = d;
    v.e_top = t; v.e_cnt = n; v.e_emp = e; v.e_full = f; v.e_ovf = o; v.e_unf = u;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", name, got, want, $time);
    end
  endtask

  task automatic compare_now(input string tag);
    exp_t x;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    x = exp_q.pop_front();
    chk({tag, "_top"}, int'(top), int'(x.top));
    chk({tag, "_count"}, int'(count), x.cnt);
    chk({tag, "_empty"}, int'(empty), int'(x.emp));
    chk({tag, "_full"}, int'(full), int'(x.full));
    chk({tag, "_ovf"}, int'(overflow), int'(x.ovf));
    chk({tag, "_unf"}, int'(underflow), int'(x.unf));
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t x;
    @(negedge clk);
    push = v.p; pop = v.q; clr_err = v.c; din = v.d;
    x.top = v.e_top; x.cnt = v.e_cnt; x.emp = v.e_emp;
    x.full = v.e_full; x.ovf = v.e_ovf; x.unf = v.e_unf;
    exp_q.push_back(x);
    #1;
    compare_now(tag);
  endtask

  task automatic expect_reset_state(input string tag);
    exp_t x;
    x.top = '0; x.cnt = 0; x.emp = 1'b1; x.full = 1'b0; x.ovf = 1'b0; x.unf = 1'b0;
    exp_q.push_back(x);
    compare_now(tag);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; din = '0;

    // idle and LIFO order
    vecs.push_back(mk(0,0,0,10'h000, 10'h000,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,10'h011, 10'h000,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,10'h022, 10'h011,1,0,0,0,0));
    vecs.push_back(mk(1,0,0,10'h033, 10'h022,2,0,0,0,0));
    vecs.push_back(mk(0,1,0,10'h000, 10'h033,3,0,0,0,0));
    vecs.push_back(mk(0,1,0,10'h000, 10'h022,2,0,0,0,0));
    vecs.push_back(mk(0,1,0,10'h000, 10'h011,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,10'h000, 10'h000,0,1,0,0,0));
    // fill to DEPTH
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back(mk(1,0,0, 10'(10'h100 + i), (i == 0) ? 10'h000 : 10'(10'h100 + i - 1),
                        i, (i == 0), 0, 0, 0));
    // overflow, clear, replace at full
    vecs.push_back(mk(1,0,0,10'h3FF, 10'h107,8,0,1,0,0));
    vecs.push_back(mk(0,0,0,10'h000, 10'h107,8,0,1,1,0));
    vecs.push_back(mk(0,0,1,10'h000, 10'h107,8,0,1,1,0));
    vecs.push_back(mk(1,1,0,10'h2AA, 10'h107,8,0,1,0,0));
    // drain
    for (int j = 0; j < DEPTH; j++)
      vecs.push_back(mk(0,1,0,10'h000, (j == 0) ? 10'h2AA : 10'(10'h100 + DEPTH - j - 1),
                        DEPTH - j, 0, (j == 0), 0, 0));
    // underflow, push+pop on empty, clear vs set priority
    vecs.push_back(mk(0,1,0,10'h000, 10'h000,0,1,0,0,0));
    vecs.push_back(mk(1,1,0,10'h055, 10'h000,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,10'h000, 10'h055,1,0,0,0,1));
    vecs.push_back(mk(0,1,1,10'h000, 10'h055,1,0,0,0,1));
    vecs.push_back(mk(0,1,1,10'h000, 10'h000,0,1,0,0,0));
    vecs.push_back(mk(0,0,1,10'h000, 10'h000,0,1,0,0,1));
    vecs.push_back(mk(0,0,0,10'h000, 10'h000,0,1,0,0,0));

    repeat (2) @(negedge clk);
    expect_reset_state("in_reset");
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++)
      apply(vecs[k], $sformatf("vec%0d", k));

    // three pushes, then async reset between edges
    apply(mk(1,0,0,10'h0A1, 10'h000,0,1,0,0,0), "ar_push0");
    apply(mk(1,0,0,10'h0A2, 10'h0A1,1,0,0,0,0), "ar_push1");
    apply(mk(1,0,0,10'h0A3, 10'h0A2,2,0,0,0,0), "ar_push2");
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    chk("ar_pre_count", int'(count), 3);
    #1 reset = 1'b1;
    #1 expect_reset_state("ar_mid");

    // push on an edge while reset is held must be discarded
    push = 1'b1; din = 10'h3AB;
    @(negedge clk);
    push = 1'b0;
    reset = 1'b0;
    #1 expect_reset_state("ar_held");

    apply(mk(0,1,0,10'h000, 10'h000,0,1,0,0,0), "ar_pop");
    apply(mk(0,0,0,10'h000, 10'h000,0,1,0,0,1), "ar_after");

    if (exp_q.size() != 0) chk("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
